// File: rtl/mips_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_wb_pkg                                                                |
// | Shared widths and queued-write entry type for the write-back controller.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
    logic                  kill;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// +----------------------------------------------------------------------------+
// | wb_fifo                                                                    |
// | Circular buffer of long-latency writes with an rd-match kill port.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output wb_entry_t               head,
  input  logic                    kill_en,
  input  logic [REG_ADDR_W-1:0]   kill_rd,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != CNT_FULL);
  assign do_pop  = pop && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Kill is evaluated against the current contents, so a same-cycle push is never killed.
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && valid_q[i] && (mem_q[i].rd == kill_rd)) begin
        mem_d[i].kill = 1'b1;
      end
    end
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_ONE;
    end
    if (do_push) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_writeback_ctrl.sv
// +----------------------------------------------------------------------------+
// | rf_writeback_ctrl                                                          |
// | Register-file write port owner: arbitrates ALU vs queued LSU results.      |
// | Optional feature macro: WB_BYPASS_EN (in-flight write bypass compare).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rf_writeback_ctrl
  import mips_wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [REG_ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [REG_ADDR_W-1:0]   lsu_rd,
  input  logic [DATA_W-1:0]       lsu_data,
  output logic                    alu_stall,
  output logic                    regWrite,
  output logic [REG_ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]       write_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    ovf_err,
  input  logic [REG_ADDR_W-1:0]   byp_reg_1,
  input  logic [REG_ADDR_W-1:0]   byp_reg_2,
  output logic                    byp_hit_1,
  output logic                    byp_hit_2,
  output logic [DATA_W-1:0]       byp_data_1,
  output logic [DATA_W-1:0]       byp_data_2
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = 1;

  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  ovf_q, ovf_d;

  logic       fifo_push, fifo_pop, fifo_empty, kill_en;
  wb_entry_t  push_entry, head;

  assign fifo_empty = (fifo_count == '0);
  assign lsu_ready  = (fifo_count != CNT_FULL);
  assign alu_stall  = (starve_q == STARVE_MAX);
  assign fifo_push  = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign push_entry = '{rd: lsu_rd, data: lsu_data, kill: 1'b0};

  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    starve_d     = '0;
    fifo_pop     = 1'b0;
    kill_en      = 1'b0;
    ovf_d        = ovf_q | (alu_valid & alu_stall);
    if (!alu_stall && alu_valid) begin
      if (alu_rd != '0) begin
        regwrite_d   = 1'b1;
        write_reg_d  = alu_rd;
        write_data_d = alu_data;
        kill_en      = 1'b1;
      end
      if (!fifo_empty) begin
        starve_d = starve_q + STARVE_ONE;
      end
    end else if (!fifo_empty) begin
      // Stall slot or idle ALU: the head drains; a killed head is simply discarded.
      fifo_pop = 1'b1;
      if (!head.kill) begin
        regwrite_d   = 1'b1;
        write_reg_d  = head.rd;
        write_data_d = head.data;
      end
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .kill_en    (kill_en),
    .kill_rd    (alu_rd),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      starve_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      starve_q     <= starve_d;
      ovf_q        <= ovf_d;
    end
  end

  assign regWrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign ovf_err    = ovf_q;

`ifdef WB_BYPASS_EN
  assign byp_hit_1  = regwrite_q && (write_reg_q == byp_reg_1) && (byp_reg_1 != '0);
  assign byp_hit_2  = regwrite_q && (write_reg_q == byp_reg_2) && (byp_reg_2 != '0);
  assign byp_data_1 = write_data_q;
  assign byp_data_2 = write_data_q;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_reg_1, byp_reg_2};
  assign byp_hit_1  = 1'b0;
  assign byp_hit_2  = 1'b0;
  assign byp_data_1 = '0;
  assign byp_data_2 = '0;
`endif

endmodule

`default_nettype wire
